// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the 8088 bus cycle controller.
// Holds the FSM state encoding, region indices, the IOM memory polarity,
// the wait-state counter width and an inclusive range-compare helper.
package bus_ctrl_pkg;

  // Wait-state value / counter width (0..7 wait states).
  localparam int WS_W = 3;

  // IOM level that selects a memory cycle.
  localparam logic ACTIVE = 1'b0;

  // Bit positions within the one-hot chip select.
  localparam int REG_MEM0 = 0;
  localparam int REG_MEM1 = 1;
  localparam int REG_IO0  = 2;
  localparam int REG_IO1  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Inclusive lo..hi test written as an offset compare so that a range
  // starting at zero or ending at the top of the space needs no special case.
  function automatic logic in_range(input logic [19:0] a,
                                    input logic [19:0] lo,
                                    input logic [19:0] hi);
    return (a - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/region_decode.sv
// Combinational address decoder: memory/IO region hit and its wait states.
// Ports: iom (cycle type), addr (latched bus address) -> hit (one-hot), ws.
// Overlapping ranges resolve to the lowest index; a miss gives hit=0, ws=0.
module region_decode
  import bus_ctrl_pkg::*;
#(
  parameter logic [19:0]     MEM0_LSB = 20'h00000,
  parameter logic [19:0]     MEM0_MSB = 20'h7FFFF,
  parameter logic [19:0]     MEM1_LSB = 20'h80000,
  parameter logic [19:0]     MEM1_MSB = 20'hFFFFF,
  parameter logic [15:0]     IO0_LSB  = 16'h00F0,
  parameter logic [15:0]     IO0_MSB  = 16'h00FF,
  parameter logic [15:0]     IO1_LSB  = 16'h0100,
  parameter logic [15:0]     IO1_MSB  = 16'h01FF,
  parameter logic [WS_W-1:0] MEM0_WS  = 3'd0,
  parameter logic [WS_W-1:0] MEM1_WS  = 3'd1,
  parameter logic [WS_W-1:0] IO0_WS   = 3'd2,
  parameter logic [WS_W-1:0] IO1_WS   = 3'd3
) (
  input  logic            iom,
  input  logic [19:0]     addr,
  output logic [3:0]      hit,
  output logic [WS_W-1:0] ws
);

  logic [3:0]  raw;
  logic [19:0] io_addr;

  // IO space is only 16 bits wide; the top nibble is ignored for IO cycles.
  assign io_addr = {4'h0, addr[15:0]};

  always_comb begin
    raw           = '0;
    raw[REG_MEM0] = (iom == ACTIVE) && in_range(addr, MEM0_LSB, MEM0_MSB);
    raw[REG_MEM1] = (iom == ACTIVE) && in_range(addr, MEM1_LSB, MEM1_MSB);
    raw[REG_IO0]  = (iom != ACTIVE) && in_range(io_addr, {4'h0, IO0_LSB}, {4'h0, IO0_MSB});
    raw[REG_IO1]  = (iom != ACTIVE) && in_range(io_addr, {4'h0, IO1_LSB}, {4'h0, IO1_MSB});

    hit           = '0;
    hit[REG_MEM0] = raw[REG_MEM0];
    hit[REG_MEM1] = raw[REG_MEM1] & ~raw[REG_MEM0];
    hit[REG_IO0]  = raw[REG_IO0]  & ~(raw[REG_MEM0] | raw[REG_MEM1]);
    hit[REG_IO1]  = raw[REG_IO1]  & ~(raw[REG_MEM0] | raw[REG_MEM1] | raw[REG_IO0]);

    ws = '0;
    if (hit[REG_MEM0])      ws = MEM0_WS;
    else if (hit[REG_MEM1]) ws = MEM1_WS;
    else if (hit[REG_IO0])  ws = IO0_WS;
    else if (hit[REG_IO1])  ws = IO1_WS;
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8088 bus cycle sequencer: latches address on ALE, drives one-hot CS,
// inserts per-region wait states on READY and flags decode/strobe errors.
// Ports: CLK, RESET (sync, active high), ALE, IOM, RD, WR, Address -> CS, READY, Err.
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter logic [19:0]     MEM0_LSB = 20'h00000,
  parameter logic [19:0]     MEM0_MSB = 20'h7FFFF,
  parameter logic [19:0]     MEM1_LSB = 20'h80000,
  parameter logic [19:0]     MEM1_MSB = 20'hFFFFF,
  parameter logic [15:0]     IO0_LSB  = 16'h00F0,
  parameter logic [15:0]     IO0_MSB  = 16'h00FF,
  parameter logic [15:0]     IO1_LSB  = 16'h0100,
  parameter logic [15:0]     IO1_MSB  = 16'h01FF,
  parameter logic [WS_W-1:0] MEM0_WS  = 3'd0,
  parameter logic [WS_W-1:0] MEM1_WS  = 3'd1,
  parameter logic [WS_W-1:0] IO0_WS   = 3'd2,
  parameter logic [WS_W-1:0] IO1_WS   = 3'd3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD,
  input  logic        WR,
  input  logic [19:0] Address,
  output logic [3:0]  CS,
  output logic        READY,
  output logic        Err
);

  state_t            state, state_nxt;
  logic [19:0]       addr_q;
  logic              iom_q;
  logic [WS_W-1:0]   cnt;
  logic              entered_q;  // first cycle of DECODE
  logic              dbl_q;      // one-cycle flag: RD and WR were both low
  logic              kill_q;     // CS suppressed until the cycle returns to IDLE
  logic [3:0]        hit;
  logic [WS_W-1:0]   ws;
  logic              strobe, both_low, both_high, in_cycle, start;

  assign strobe    = ~RD | ~WR;
  assign both_low  = ~RD & ~WR;
  assign both_high = RD & WR;
  assign start     = (state == ST_IDLE) && ALE;
  assign in_cycle  = (state == ST_DECODE) || (state == ST_WAIT) || (state == ST_ACTIVE);

  region_decode #(
    .MEM0_LSB(MEM0_LSB), .MEM0_MSB(MEM0_MSB),
    .MEM1_LSB(MEM1_LSB), .MEM1_MSB(MEM1_MSB),
    .IO0_LSB (IO0_LSB),  .IO0_MSB (IO0_MSB),
    .IO1_LSB (IO1_LSB),  .IO1_MSB (IO1_MSB),
    .MEM0_WS (MEM0_WS),  .MEM1_WS (MEM1_WS),
    .IO0_WS  (IO0_WS),   .IO1_WS  (IO1_WS)
  ) u_decode (
    .iom (iom_q),
    .addr(addr_q),
    .hit (hit),
    .ws  (ws)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state. A decode miss has ws=0, so it walks DECODE -> ACTIVE.
  // ACTIVE already waits for both strobes high, so RELEASE is never entered.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ALE) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (both_low)    state_nxt = ST_ACTIVE;
        else if (strobe) state_nxt = (ws != '0) ? ST_WAIT : ST_ACTIVE;
      end
      ST_WAIT: begin
        if (both_low)                  state_nxt = ST_ACTIVE;
        else if (both_high)            state_nxt = ST_IDLE;
        else if (cnt <= WS_W'(1))      state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: if (both_high) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Address latch, wait counter and error/suppress flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q    <= '0;
      iom_q     <= 1'b0;
      cnt       <= '0;
      entered_q <= 1'b0;
      dbl_q     <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      entered_q <= start;
      if (start) begin
        addr_q <= Address;
        iom_q  <= IOM;
      end

      // The counter holds W on the first WAIT cycle and leaves WAIT when it
      // would reach 0, giving exactly W low cycles on READY.
      if (state_nxt == ST_WAIT) begin
        if (state == ST_DECODE) cnt <= ws;
        else                    cnt <= cnt - WS_W'(1);
      end else begin
        cnt <= '0;
      end

      dbl_q <= in_cycle && both_low && !kill_q;
      if (state_nxt == ST_IDLE)       kill_q <= 1'b0;
      else if (in_cycle && both_low)  kill_q <= 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    CS    = (in_cycle && !kill_q) ? hit : 4'b0000;
    READY = (state != ST_WAIT);
    Err   = dbl_q || (entered_q && (hit == 4'b0000));
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: memory/IO cycles, wait states, errors,
// reset during WAIT and ignored ALE. Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_bus_cycle_ctrl;
  import bus_ctrl_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic [19:0] Address;
  logic [3:0]  CS;
  logic        READY;
  logic        Err;

  int vectors = 0;
  int errs    = 0;

  bus_cycle_ctrl dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ALE    (ALE),
    .IOM    (IOM),
    .RD     (RD),
    .WR     (WR),
    .Address(Address),
    .CS     (CS),
    .READY  (READY),
    .Err    (Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] cs_e,
                         input logic rdy_e, input logic err_e);
    chk({tag, ".cs"},    32'(CS),    32'(cs_e));
    chk({tag, ".ready"}, 32'(READY), 32'(rdy_e));
    chk({tag, ".err"},   32'(Err),   32'(err_e));
  endtask

  initial begin
    RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; Address = '0;
    tick(); tick();
    chk_out("reset", 4'b0000, 1'b1, 1'b0);
    chk("reset.state", 32'(dut.state), 32'(ST_IDLE));
    RESET = 1'b0;
    tick();
    chk_out("idle", 4'b0000, 1'b1, 1'b0);

    // Memory read, MEM0, no wait states.
    ALE = 1'b1; IOM = 1'b0; Address = 20'h12345;
    tick();
    ALE = 1'b0; Address = 20'hFFFFF;
    chk_out("m0.decode", 4'b0001, 1'b1, 1'b0);
    RD = 1'b0;
    tick();
    chk_out("m0.act", 4'b0001, 1'b1, 1'b0);
    tick();
    chk_out("m0.hold", 4'b0001, 1'b1, 1'b0);
    RD = 1'b1;
    tick();
    chk_out("m0.rel", 4'b0000, 1'b1, 1'b0);
    chk("m0.state", 32'(dut.state), 32'(ST_IDLE));

    // Memory write, MEM1, one wait state.
    ALE = 1'b1; Address = 20'h9ABCD;
    tick();
    ALE = 1'b0;
    chk_out("m1.decode", 4'b0010, 1'b1, 1'b0);
    WR = 1'b0;
    tick();
    chk_out("m1.ws1", 4'b0010, 1'b0, 1'b0);
    tick();
    chk_out("m1.act", 4'b0010, 1'b1, 1'b0);
    WR = 1'b1;
    tick();
    chk_out("m1.rel", 4'b0000, 1'b1, 1'b0);

    // IO read, IO0, two wait states.
    ALE = 1'b1; IOM = 1'b1; Address = 20'hF00F4;
    tick();
    ALE = 1'b0;
    chk_out("io0.decode", 4'b0100, 1'b1, 1'b0);
    RD = 1'b0;
    tick();
    chk_out("io0.ws1", 4'b0100, 1'b0, 1'b0);
    tick();
    chk_out("io0.ws2", 4'b0100, 1'b0, 1'b0);
    tick();
    chk_out("io0.act", 4'b0100, 1'b1, 1'b0);
    RD = 1'b1;
    tick();
    chk_out("io0.rel", 4'b0000, 1'b1, 1'b0);

    // IO write, IO1, three wait states, started with no idle gap.
    ALE = 1'b1; Address = 20'h001A0;
    tick();
    ALE = 1'b0;
    chk_out("io1.decode", 4'b1000, 1'b1, 1'b0);
    WR = 1'b0;
    tick();
    chk_out("io1.ws1", 4'b1000, 1'b0, 1'b0);
    tick();
    chk_out("io1.ws2", 4'b1000, 1'b0, 1'b0);
    tick();
    chk_out("io1.ws3", 4'b1000, 1'b0, 1'b0);
    tick();
    chk_out("io1.act", 4'b1000, 1'b1, 1'b0);
    WR = 1'b1;
    tick();
    chk_out("io1.rel", 4'b0000, 1'b1, 1'b0);

    // IO decode miss: Err for exactly one cycle, READY stays high.
    ALE = 1'b1; Address = 20'h00300;
    tick();
    ALE = 1'b0;
    chk_out("miss.decode", 4'b0000, 1'b1, 1'b1);
    tick();
    chk_out("miss.decode2", 4'b0000, 1'b1, 1'b0);
    RD = 1'b0;
    tick();
    chk_out("miss.act", 4'b0000, 1'b1, 1'b0);
    chk("miss.state", 32'(dut.state), 32'(ST_ACTIVE));
    RD = 1'b1;
    tick();
    chk("miss.idle", 32'(dut.state), 32'(ST_IDLE));

    // Valid cycle right after the miss decodes normally.
    ALE = 1'b1; IOM = 1'b0; Address = 20'h12345;
    tick();
    ALE = 1'b0;
    chk_out("after_miss", 4'b0001, 1'b1, 1'b0);
    RD = 1'b0;
    tick();
    RD = 1'b1;
    tick();
    chk_out("after_miss.rel", 4'b0000, 1'b1, 1'b0);

    // RD and WR both low: Err pulse, CS cleared, READY high.
    ALE = 1'b1; IOM = 1'b1; Address = 20'h00100;
    tick();
    ALE = 1'b0;
    chk_out("dbl.decode", 4'b1000, 1'b1, 1'b0);
    RD = 1'b0; WR = 1'b0;
    tick();
    chk_out("dbl.err", 4'b0000, 1'b1, 1'b1);
    chk("dbl.state", 32'(dut.state), 32'(ST_ACTIVE));
    tick();
    chk_out("dbl.hold", 4'b0000, 1'b1, 1'b0);
    RD = 1'b1; WR = 1'b1;
    tick();
    chk("dbl.idle", 32'(dut.state), 32'(ST_IDLE));

    // Strobe released during WAIT: back to IDLE, CS cleared.
    ALE = 1'b1; Address = 20'h001A0;
    tick();
    ALE = 1'b0;
    WR = 1'b0;
    tick();
    chk_out("abort.ws1", 4'b1000, 1'b0, 1'b0);
    WR = 1'b1;
    tick();
    chk_out("abort.rel", 4'b0000, 1'b1, 1'b0);
    chk("abort.state", 32'(dut.state), 32'(ST_IDLE));

    // RESET during an IO1 WAIT.
    ALE = 1'b1; Address = 20'h00150;
    tick();
    ALE = 1'b0;
    WR = 1'b0;
    tick();
    chk_out("rst.ws1", 4'b1000, 1'b0, 1'b0);
    RESET = 1'b1;
    tick();
    chk_out("rst.out", 4'b0000, 1'b1, 1'b0);
    chk("rst.state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst.cnt", 32'(dut.cnt), 32'd0);
    RESET = 1'b0; WR = 1'b1;
    tick();

    // Second ALE during ACTIVE is ignored.
    ALE = 1'b1; IOM = 1'b0; Address = 20'h12345;
    tick();
    ALE = 1'b0;
    RD = 1'b0;
    tick();
    chk_out("ale2.act", 4'b0001, 1'b1, 1'b0);
    ALE = 1'b1; Address = 20'h9ABCD;
    tick();
    ALE = 1'b0;
    chk_out("ale2.ignored", 4'b0001, 1'b1, 1'b0);
    RD = 1'b1;
    tick();
    chk_out("ale2.rel", 4'b0000, 1'b1, 1'b0);
    tick();
    chk("ale2.state", 32'(dut.state), 32'(ST_IDLE));
    chk_out("ale2.idle", 4'b0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
